// File: rtl/ram_bus_arbiter_pkg.sv
// arb_pkg: shared types for the data-RAM port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GNT_CPU, GNT_DBG, ACK)
//   owner_t     : 2-bit grant owner code driven on the owner port
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_DBG = 2'd2,
    ACK     = 2'd3
  } arb_state_t;

  typedef logic [1:0] owner_t;

  localparam owner_t OWN_NONE = 2'b00;
  localparam owner_t OWN_CPU  = 2'b01;
  localparam owner_t OWN_DBG  = 2'b10;

endpackage

// File: rtl/ram_bus_arbiter_if.sv
// ram_bus_arbiter_if: bundles the CPU request port, the debug/loader
// request port and the shared RAM port.
//   cpu_* / dbg_* : req, we, addr, wdata in; ack pulse and held rdata out
//   ram_*         : cs, we, addr, wdata out; rdata in (same-cycle valid)
//   owner         : current grant (00 none, 01 cpu, 10 dbg)
// Modports: slave = arbiter side, master = requesters + RAM side.
interface ram_bus_arbiter_if
  import arb_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;

  logic              ram_cs;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  owner_t            owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata,
    output ram_cs, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata,
    input  ram_cs, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  owner
  );

endinterface

// File: rtl/ram_bus_arbiter_starve_cnt.sv
// arb_starve_cnt: saturating count of CPU grants taken while the debug
// port is waiting.
//   clk, reset : clock, synchronous active-high reset
//   inc        : count one CPU grant (holds once saturated)
//   clr        : return to zero (wins over inc)
//   sat        : count has reached STARVE_MAX
module arb_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= 4'd0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign sat = (cnt_q == CNT_MAX);

endmodule

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: shares one data-RAM port between the CPU datapath and
// the debug/loader port. Each access takes a grant cycle (RAM strobed)
// followed by an ack cycle; arbitration happens in IDLE and ACK.
//   clk, reset : clock, synchronous active-high reset
//   bus        : ram_bus_arbiter_if.slave (cpu_*, dbg_*, ram_*, owner)
// Build option ARB_ROUND_ROBIN_EN: replaces CPU priority + starvation guard
// with a round-robin tie-break (last granted requester loses the tie).
//
// state   | meaning
// IDLE    | no access in flight, arbitrating
// GNT_CPU | RAM strobed with the CPU request
// GNT_DBG | RAM strobed with the debug request
// ACK     | ack to last grantee, arbitrating (grantee's req masked)
module ram_bus_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 4,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              reset,
  ram_bus_arbiter_if.slave bus
);

  arb_state_t        state_q, state_d, arb_next;
  logic              last_cpu_q;  // 1: CPU granted last, 0: debug (reset)
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic              in_ack, cpu_elig, dbg_elig, dbg_win, cpu_win;

  // A requester still shows req during its own ack cycle; mask it there so
  // the same access is not granted twice.
  assign in_ack   = (state_q == ACK);
  assign cpu_elig = bus.cpu_req && !(in_ack && last_cpu_q);
  assign dbg_elig = bus.dbg_req && !(in_ack && !last_cpu_q);

`ifdef ARB_ROUND_ROBIN_EN
  assign dbg_win = dbg_elig && (!cpu_elig || last_cpu_q);
`else
  logic starve_sat;

  arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   ((state_q == GNT_CPU) && bus.dbg_req),
    .clr   ((state_q == GNT_DBG) || !bus.dbg_req),
    .sat   (starve_sat)
  );

  // Priority is judged on the raw CPU request: a CPU that keeps requesting
  // through its own ack still holds debug off until the guard saturates.
  assign dbg_win = dbg_elig && (!bus.cpu_req || starve_sat);
`endif

  assign cpu_win  = cpu_elig && !dbg_win;
  assign arb_next = dbg_win ? GNT_DBG : (cpu_win ? GNT_CPU : IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_cpu_q  <= 1'b0;
      cpu_rdata_q <= {DATA_W{1'b0}};
      dbg_rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      if (state_q == GNT_CPU) begin
        last_cpu_q <= 1'b1;
        if (!bus.cpu_we) cpu_rdata_q <= bus.ram_rdata;
      end
      if (state_q == GNT_DBG) begin
        last_cpu_q <= 1'b0;
        if (!bus.dbg_we) dbg_rdata_q <= bus.ram_rdata;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.ram_cs    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = {ADDR_W{1'b0}};
    bus.ram_wdata = {DATA_W{1'b0}};
    bus.owner     = OWN_NONE;
    bus.cpu_ack   = 1'b0;
    bus.dbg_ack   = 1'b0;
    case (state_q)
      GNT_CPU: begin
        bus.ram_cs    = 1'b1;
        bus.ram_we    = bus.cpu_we;
        bus.ram_addr  = bus.cpu_addr;
        bus.ram_wdata = bus.cpu_wdata;
        bus.owner     = OWN_CPU;
        state_d       = ACK;
      end
      GNT_DBG: begin
        bus.ram_cs    = 1'b1;
        bus.ram_we    = bus.dbg_we;
        bus.ram_addr  = bus.dbg_addr;
        bus.ram_wdata = bus.dbg_wdata;
        bus.owner     = OWN_DBG;
        state_d       = ACK;
      end
      ACK: begin
        bus.cpu_ack = last_cpu_q;
        bus.dbg_ack = !last_cpu_q;
        state_d     = arb_next;
      end
      default: state_d = arb_next;
    endcase
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb_ram_bus_arbiter: directed scenarios followed by random traffic, each
// cycle compared against a transaction-level reference model.
module tb_ram_bus_arbiter;
  import arb_pkg::*;

  localparam int AW   = 12;
  localparam int DW   = 4;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM environment: combinational read, writes committed by step().
  logic [DW-1:0] ram_mem [4096];
  assign bus.ram_rdata = ram_mem[bus.ram_addr];

  // Reference model: who holds the grant this cycle, who gets acked this
  // cycle (0 none, 1 cpu, 2 dbg), starvation count, last grantee, read regs.
  int            m_grant, m_ack, m_starve, m_last;
  logic [DW-1:0] m_cpu_rd, m_dbg_rd;
  logic [DW-1:0] m_mem [4096];

  int n_cmp = 0;
  int n_err = 0;
  bit hold_cpu = 0, hold_dbg = 0;

  logic          obs_cs, obs_we, obs_cpu_ack, obs_dbg_ack;
  logic [1:0]    obs_owner;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_cpu_rdata, obs_dbg_rdata;

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(logic [AW-1:0] a, logic [DW-1:0] d);
    ram_mem[a] = d;
    m_mem[a]   = d;
  endtask

  task automatic step();
    int            eg, ng;
    logic          ewe, ce, de, cpu_acked, dbg_acked, wr_en;
    logic [AW-1:0] ead, wr_a;
    logic [DW-1:0] ewd, wr_d;
    @(negedge clk);
    eg = m_grant;
    ewe = 1'b0; ead = '0; ewd = '0;
    if (eg == 1) begin
      ewe = bus.cpu_we; ead = bus.cpu_addr; ewd = bus.cpu_wdata;
    end else if (eg == 2) begin
      ewe = bus.dbg_we; ead = bus.dbg_addr; ewd = bus.dbg_wdata;
    end
    chk("ram_cs",    16'(bus.ram_cs),    16'(eg != 0));
    chk("ram_we",    16'(bus.ram_we),    16'(ewe));
    chk("ram_addr",  16'(bus.ram_addr),  16'(ead));
    chk("ram_wdata", 16'(bus.ram_wdata), 16'(ewd));
    chk("owner",     16'(bus.owner),     16'(eg));
    chk("cpu_ack",   16'(bus.cpu_ack),   16'(m_ack == 1));
    chk("dbg_ack",   16'(bus.dbg_ack),   16'(m_ack == 2));
    chk("cpu_rdata", 16'(bus.cpu_rdata), 16'(m_cpu_rd));
    chk("dbg_rdata", 16'(bus.dbg_rdata), 16'(m_dbg_rd));
    obs_cs = bus.ram_cs; obs_we = bus.ram_we; obs_addr = bus.ram_addr;
    obs_owner = bus.owner; obs_cpu_ack = bus.cpu_ack; obs_dbg_ack = bus.dbg_ack;
    obs_cpu_rdata = bus.cpu_rdata; obs_dbg_rdata = bus.dbg_rdata;
    wr_en = bus.ram_cs && bus.ram_we; wr_a = bus.ram_addr; wr_d = bus.ram_wdata;
    cpu_acked = (m_ack == 1);
    dbg_acked = (m_ack == 2);
    // A strobed write reaches the RAM even if reset is asserted that cycle.
    if (eg != 0 && ewe) m_mem[ead] = ewd;
    if (reset) begin
      m_grant = 0; m_ack = 0; m_starve = 0; m_last = 2;
      m_cpu_rd = '0; m_dbg_rd = '0;
    end else if (eg != 0) begin
      if (!ewe) begin
        if (eg == 1) m_cpu_rd = m_mem[ead];
        else         m_dbg_rd = m_mem[ead];
      end
      if (!bus.dbg_req || eg == 2) m_starve = 0;
      else if (m_starve < SMAX)    m_starve++;
      m_last = eg; m_ack = eg; m_grant = 0;
    end else begin
      ce = bus.cpu_req && (m_ack != 1);
      de = bus.dbg_req && (m_ack != 2);
`ifdef ARB_ROUND_ROBIN_EN
      if (ce && de) ng = (m_last == 2) ? 1 : 2;
      else          ng = de ? 2 : (ce ? 1 : 0);
`else
      if (de && (!bus.cpu_req || m_starve == SMAX)) ng = 2;
      else if (ce)                                   ng = 1;
      else                                           ng = 0;
`endif
      if (!bus.dbg_req) m_starve = 0;
      m_ack = 0; m_grant = ng;
    end
    @(posedge clk);
    if (wr_en) ram_mem[wr_a] = wr_d;
    #1;
    if (cpu_acked && !hold_cpu) bus.cpu_req = 1'b0;
    if (dbg_acked && !hold_dbg) bus.dbg_req = 1'b0;
  endtask

  logic [1:0] glog[$];
  bit         got;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram_mem[i] = '0;
      m_mem[i]   = '0;
    end
    m_grant = 0; m_ack = 0; m_starve = 0; m_last = 2;
    m_cpu_rd = '0; m_dbg_rd = '0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    step();
    reset = 1'b0;

    // CPU read of 0x123 returning 0xA: grant in cycle 1, ack in cycle 2.
    preload(12'h123, 4'hA);
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 12'h123;
    step();
    chk("t1_c0_cs", 16'(obs_cs), 16'd0);
    step();
    chk("t1_c1_cs", 16'(obs_cs), 16'd1);
    chk("t1_c1_owner", 16'(obs_owner), 16'd1);
    chk("t1_c1_addr", 16'(obs_addr), 16'h123);
    step();
    chk("t1_c2_ack", 16'(obs_cpu_ack), 16'd1);
    chk("t1_c2_rdata", 16'(obs_cpu_rdata), 16'hA);
    chk("t1_c2_owner", 16'(obs_owner), 16'd0);
    step();

    // Simultaneous CPU write and debug read: CPU first, then debug.
    preload(12'h020, 4'h9);
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 12'h010; bus.cpu_wdata = 4'h5;
    bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 12'h020;
    step();
    step();
    chk("t2_first_owner", 16'(obs_owner), 16'd1);
    chk("t2_first_we", 16'(obs_we), 16'd1);
    step();
    chk("t2_cpu_ack", 16'(obs_cpu_ack), 16'd1);
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      got = obs_dbg_ack;
    end
    chk("t2_dbg_acked", 16'(got), 16'd1);
    chk("t2_dbg_rdata", 16'(obs_dbg_rdata), 16'h9);
    chk("t2_ram_written", 16'(ram_mem[12'h010]), 16'h5);
    bus.dbg_req = 0;
    step();

    // Both requesting continuously: grant pattern.
    reset = 1; step(); reset = 0; step();
    hold_cpu = 1; hold_dbg = 1;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 12'h001;
    bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 12'h002;
    for (int i = 0; i < 50; i++) begin
      step();
      if (obs_owner != 2'b00) glog.push_back(obs_owner);
    end
    chk("t3_grant_count", 16'(glog.size() >= 10), 16'd1);
    for (int i = 0; i < 10 && i < glog.size(); i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      chk($sformatf("t3_grant%0d", i), 16'(glog[i]), (i % 2 == 0) ? 16'd1 : 16'd2);
`else
      chk($sformatf("t3_grant%0d", i), 16'(glog[i]), (i % 5 == 4) ? 16'd2 : 16'd1);
`endif
    end
    hold_cpu = 0; hold_dbg = 0;
    bus.cpu_req = 0; bus.dbg_req = 0;
    step(); step(); step();

    // Reset during a debug grant: no ack, everything quiet next cycle.
    reset = 1; step(); reset = 0; step();
    preload(12'h055, 4'hC);
    bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 12'h055;
    step();
    reset = 1; bus.dbg_req = 0;
    step();
    chk("t4_gnt_owner", 16'(obs_owner), 16'd2);
    reset = 0;
    step();
    chk("t4_no_ack", 16'(obs_dbg_ack), 16'd0);
    chk("t4_cs_low", 16'(obs_cs), 16'd0);
    chk("t4_owner", 16'(obs_owner), 16'd0);
    chk("t4_rdata", 16'(obs_dbg_rdata), 16'd0);
    step();

    // Debug write then read at the top address.
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 12'hFFF; bus.dbg_wdata = 4'h7;
    step();
    step();
    chk("t5_wr_addr", 16'(obs_addr), 16'hFFF);
    step();
    chk("t5_wr_ack", 16'(obs_dbg_ack), 16'd1);
    chk("t5_wr_rdata", 16'(obs_dbg_rdata), 16'd0);
    step();
    bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 12'hFFF;
    step();
    step();
    chk("t5_rd_addr", 16'(obs_addr), 16'hFFF);
    step();
    chk("t5_rd_ack", 16'(obs_dbg_ack), 16'd1);
    chk("t5_rd_rdata", 16'(obs_dbg_rdata), 16'h7);
    step();

    // Random traffic from both ports, occasional reset pulses.
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (!bus.cpu_req && $urandom_range(0, 2) == 0) begin
        bus.cpu_req   = 1;
        bus.cpu_we    = 1'($urandom_range(0, 1));
        bus.cpu_addr  = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 7));
        bus.cpu_wdata = 4'($urandom_range(0, 15));
      end
      if (!bus.dbg_req && $urandom_range(0, 2) == 0) begin
        bus.dbg_req   = 1;
        bus.dbg_we    = 1'($urandom_range(0, 1));
        bus.dbg_addr  = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 7));
        bus.dbg_wdata = 4'($urandom_range(0, 15));
      end
      step();
    end
    reset = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
- Shares the single data RAM port (12-bit address, 4-bit data) between the CPU datapath and a debug/loader port.
- Sits between the microcode-driven RAM control signals and the RAM.
- Fixed CPU priority, with a starvation guard that forces periodic debug grants.
- One access per two cycles: grant cycle, then ack cycle.

Parameters:
- ADDR_W, 12, address width
- DATA_W, 4, data width
- STARVE_MAX, 4, consecutive CPU grants while dbg_req is pending before debug is forced to win (range 1..15)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request; held with cpu_we/addr/wdata stable until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  last CPU read data, held
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata  (same directions, widths and meanings as cpu_*, for the debug port)
- ram_cs  out  1  RAM chip select
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid in the same cycle as ram_cs
- owner  out  2  00 none, 01 cpu, 10 dbg (current grant)

Behaviour:
- Reset:
  - State IDLE; starve_cnt = 0.
  - All outputs 0: acks, rdata regs, ram_cs, ram_we, ram_addr, ram_wdata, owner.
  - A transaction in flight is dropped; no ack is issued for it.
- States: IDLE, GNT_CPU, GNT_DBG, ACK.
- Arbitration runs in IDLE and ACK:
  - In ACK, the req of the requester just acked is masked.
  - Debug wins if dbg_req and (not cpu_req, or starve_cnt == STARVE_MAX).
  - Otherwise CPU wins if cpu_req.
  - No eligible request: next state IDLE.
- GNT_x (1 cycle):
  - ram_cs = 1; ram_we/addr/wdata muxed combinationally from requester x.
  - owner = x.
  - On a read, ram_rdata is registered into x_rdata at the clock edge ending the cycle.
  - Always followed by ACK.
- ACK (1 cycle):
  - x_ack = 1; ram_cs = 0.
  - Arbitration chooses the next state.
  - x_rdata is valid during ACK and holds until x's next read completes; writes never change x_rdata.
- Outside GNT: ram_we = 0, ram_addr = 0, ram_wdata = 0, owner = 00.
- Latency: request seen in IDLE gives grant next cycle and ack the cycle after (req-to-ack = 2 cycles). Peak throughput is 1 access per 2 cycles.
- starve_cnt:
  - Increments on each CPU grant while dbg_req = 1, saturating at STARVE_MAX.
  - Clears on a debug grant, or any cycle with dbg_req = 0.
- Req dropped during GNT: the access still completes and ack still pulses.
- Both requesting in IDLE with starve_cnt < STARVE_MAX: CPU wins.
- Reset asserted during GNT: no ack; ram_cs = 0 the next cycle.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: fixed priority and starve_cnt are removed (STARVE_MAX ignored). A last_owner register, reset to dbg, gives the tie to the requester not granted last. A lone requester always wins.
- Undefined: fixed priority with starvation guard, as described above.

Decomposition:
- Package arb_pkg:
  - typedef enum arb_state_t {IDLE, GNT_CPU, GNT_DBG, ACK}
  - typedef owner_t (2-bit) with constants OWN_NONE / OWN_CPU / OWN_DBG
- One sub-module, arb_starve_cnt: saturating counter with inc, clr and sat outputs, instantiated only when ARB_ROUND_ROBIN_EN is undefined.

Test Plan:
- Reset, then cpu_req read, addr 0x123, RAM returns 0xA -> ram_cs in cycle 1, cpu_ack and cpu_rdata = 0xA in cycle 2, owner 01 then 00.
- Simultaneous cpu write (0x010, 0x5) and dbg read (0x020) -> CPU granted first, ack; dbg granted in the CPU's ACK cycle+1; dbg_rdata = RAM value.
- cpu_req held continuously, dbg_req held, STARVE_MAX = 4 -> exactly 4 CPU grants, then 1 dbg grant, then the pattern repeats.
- Reset asserted in GNT_DBG -> no dbg_ack, all outputs 0 next cycle, dbg_rdata stays 0.
- Debug write 0x7 to 0xFFF, then read 0xFFF -> dbg_rdata unchanged by the write, 0x7 after the read; ram_addr = 0xFFF (top address, no wrap).
- With ARB_ROUND_ROBIN_EN defined, both requesting continuously -> grants alternate dbg? no: cpu, dbg, cpu, dbg (last_owner reset = dbg).
